// File: rtl/reloj_pkg.sv
// Shared types, limits and the BCD range check for the HH:MM:SS counter.
package reloj_pkg;

   // One BCD byte: [7:4] tens digit, [3:0] units digit.
   typedef logic [7:0] bcd_t;

   localparam bcd_t SEC_MAX = 8'h59;
   localparam bcd_t MIN_MAX = 8'h59;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      ACK   = 2'd2
   } set_state_t;

   // True when both nibbles are decimal digits and the byte does not exceed max.
   function automatic logic bcd_valid(input bcd_t b, input bcd_t max);
      return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b <= max);
   endfunction

endpackage

// File: rtl/reloj_bcd_digit_pair.sv
// Two-digit BCD counter that wraps at MAX, with parallel load and carry out.
module reloj_bcd_digit_pair
   import reloj_pkg::*;
#(
   parameter bcd_t MAX = 8'h59
) (
   input  logic clock,
   input  logic reset_n,
   input  logic inc,
   input  logic load,
   input  bcd_t load_val,
   output bcd_t value,
   output logic carry
);

   bcd_t r_value;
   bcd_t w_value_next;
   logic w_at_max;

   assign w_at_max = (r_value == MAX);

   // BCD increment: wrap at MAX, x9 -> (x+1)0, otherwise bump the units digit.
   always_comb begin
      w_value_next = r_value;
      if (w_at_max) begin
         w_value_next = 8'h00;
      end else if (r_value[3:0] == 4'd9) begin
         w_value_next = {r_value[7:4] + 4'd1, 4'd0};
      end else begin
         w_value_next = {r_value[7:4], r_value[3:0] + 4'd1};
      end
   end

   // Value register; a load takes priority over an increment.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_value <= 8'h00;
      end else if (load) begin
         r_value <= load_val;
      end else if (inc) begin
         r_value <= w_value_next;
      end
   end

   assign value = r_value;
   assign carry = inc & w_at_max;

endmodule

// File: rtl/reloj_hms_counter.sv
// 24 h BCD time-of-day counter advanced by rising edges of an external 1 Hz
// wave, with a request/acknowledge time-set port that rejects out-of-range loads.
module reloj_hms_counter
   import reloj_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,      // at least 2 flops on the async wave
   parameter bcd_t HOUR_MAX    = 8'h23
) (
   input  logic clock,
   input  logic reset_n,
   input  logic sec_wave,
   input  logic run,
   input  logic set_req,
   input  bcd_t set_hh,
   input  bcd_t set_mm,
   input  bcd_t set_ss,
   output logic set_ack,
   output logic set_err,
   output bcd_t hh,
   output bcd_t mm,
   output bcd_t ss,
   output logic sec_pulse,
   output logic day_roll
);

   // Synchroniser chain and edge history. All reset high so a wave that is
   // already high when reset releases does not count as a second.
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_tick;

   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            // First stage samples the asynchronous wave.
            always_ff @(posedge clock or negedge reset_n) begin
               if (!reset_n) r_sync[gi] <= 1'b1;
               else          r_sync[gi] <= sec_wave;
            end
         end else begin : g_rest
            // Further stages settle any metastability from the first.
            always_ff @(posedge clock or negedge reset_n) begin
               if (!reset_n) r_sync[gi] <= 1'b1;
               else          r_sync[gi] <= r_sync[gi-1];
            end
         end
      end
   endgenerate

   // Edge-history flop for rising-edge detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_prev <= 1'b1;
      else          r_prev <= r_sync[SYNC_STAGES-1];
   end

   assign w_tick = r_sync[SYNC_STAGES-1] & ~r_prev;

   // Set FSM and its capture/validation state.
   set_state_t r_state;
   set_state_t w_state_next;
   logic       r_armed;
   logic       r_err;
   bcd_t       r_hold_hh;
   bcd_t       r_hold_mm;
   bcd_t       r_hold_ss;
   logic       w_start;
   logic       w_valid;
   logic       w_load;
   logic       w_adv;

   assign w_start = (r_state == IDLE) & set_req & r_armed;
   assign w_valid = bcd_valid(r_hold_hh, HOUR_MAX) &
                    bcd_valid(r_hold_mm, MIN_MAX) &
                    bcd_valid(r_hold_ss, SEC_MAX);
   assign w_load  = (r_state == CHECK) & w_valid;

   // A second is accepted only when idle and not colliding with a load start;
   // ticks during CHECK/ACK or with run low are simply lost.
   assign w_adv   = w_tick & run & (r_state == IDLE) & ~w_start;

   // FSM state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   // FSM next-state: IDLE -> CHECK on an armed request, then one cycle each.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_state_next = CHECK;
         CHECK:   w_state_next = ACK;
         ACK:     w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Armed disarms on a load start and re-arms whenever set_req is seen low,
   // so a held request yields a single load.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)      r_armed <= 1'b1;
      else if (w_start)  r_armed <= 1'b0;
      else if (!set_req) r_armed <= 1'b1;
   end

   // Capture the requested time on entry to CHECK; latch the verdict in CHECK.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_hold_hh <= 8'h00;
         r_hold_mm <= 8'h00;
         r_hold_ss <= 8'h00;
         r_err     <= 1'b0;
      end else begin
         if (w_start) begin
            r_hold_hh <= set_hh;
            r_hold_mm <= set_mm;
            r_hold_ss <= set_ss;
         end
         if (r_state == CHECK) begin
            r_err <= ~w_valid;
         end
      end
   end

   // Counter chain: seconds -> minutes -> hours, linked by carry.
   logic w_ss_carry;
   logic w_mm_carry;
   logic w_hh_carry;

   reloj_bcd_digit_pair #(.MAX(SEC_MAX)) u_ss (
      .clock    (clock),
      .reset_n  (reset_n),
      .inc      (w_adv),
      .load     (w_load),
      .load_val (r_hold_ss),
      .value    (ss),
      .carry    (w_ss_carry)
   );

   reloj_bcd_digit_pair #(.MAX(MIN_MAX)) u_mm (
      .clock    (clock),
      .reset_n  (reset_n),
      .inc      (w_ss_carry),
      .load     (w_load),
      .load_val (r_hold_mm),
      .value    (mm),
      .carry    (w_mm_carry)
   );

   reloj_bcd_digit_pair #(.MAX(HOUR_MAX)) u_hh (
      .clock    (clock),
      .reset_n  (reset_n),
      .inc      (w_mm_carry),
      .load     (w_load),
      .load_val (r_hold_hh),
      .value    (hh),
      .carry    (w_hh_carry)
   );

   // Registered status pulses, aligned with the counter update.
   logic r_sec_pulse;
   logic r_day_roll;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sec_pulse <= 1'b0;
         r_day_roll  <= 1'b0;
      end else begin
         r_sec_pulse <= w_adv;
         r_day_roll  <= w_hh_carry;
      end
   end

   assign sec_pulse = r_sec_pulse;
   assign day_roll  = r_day_roll;
   assign set_ack   = (r_state == ACK);
   assign set_err   = (r_state == ACK) & r_err;

endmodule

// File: tb/tb_reloj_hms_counter.sv
// Directed bench for the HH:MM:SS counter: latency, wrap, rejects, run, set handshake, reset.
module tb_reloj_hms_counter;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       sec_wave;
   logic       run;
   logic       set_req;
   logic [7:0] set_hh, set_mm, set_ss;
   logic       set_ack, set_err;
   logic [7:0] hh, mm, ss;
   logic       sec_pulse, day_roll;

   int n_tests = 0;
   int n_fail  = 0;

   reloj_hms_counter #(.SYNC_STAGES(2), .HOUR_MAX(8'h23)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .sec_wave  (sec_wave),
      .run       (run),
      .set_req   (set_req),
      .set_hh    (set_hh),
      .set_mm    (set_mm),
      .set_ss    (set_ss),
      .set_ack   (set_ack),
      .set_err   (set_err),
      .hh        (hh),
      .mm        (mm),
      .ss        (ss),
      .sec_pulse (sec_pulse),
      .day_roll  (day_roll)
   );

   always #5 clock = ~clock;

   task automatic chk_t(input string tag, input logic [23:0] exp);
      logic [23:0] obs;
      obs = {hh, mm, ss};
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("[TB] %s time observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
      $display("[TB] %s observed %b expected %b", tag, obs, exp);
   endtask

   task automatic chk_n(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs == exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
      $display("[TB] %s observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
   endtask

   // One full sec_wave period (low 3, high 4 cycles); counts pulses seen.
   task automatic sec_edge(output int pulses, output int rolls);
      pulses = 0;
      rolls  = 0;
      sec_wave = 1'b0;
      repeat (3) begin cyc(); pulses += int'(sec_pulse); rolls += int'(day_roll); end
      sec_wave = 1'b1;
      repeat (4) begin cyc(); pulses += int'(sec_pulse); rolls += int'(day_roll); end
   endtask

   // Issue a set request and wait (bounded) for the acknowledge.
   task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         output logic ack, output logic err);
      set_hh = h; set_mm = m; set_ss = s;
      set_req = 1'b1;
      ack = 1'b0;
      err = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (set_ack) begin
            ack = 1'b1;
            err = set_err;
            break;
         end
      end
      set_req = 1'b0;
      cyc();
   endtask

   initial begin
      int   p, r, acks;
      logic a, e;

      reset_n = 1'b0; sec_wave = 1'b1; run = 1'b1; set_req = 1'b0;
      set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00;
      repeat (3) cyc();
      chk_t("reset_time", 24'h000000);
      chk_b("reset_ack", set_ack, 1'b0);
      chk_b("reset_err", set_err, 1'b0);
      chk_b("reset_pulse", sec_pulse, 1'b0);
      chk_b("reset_roll", day_roll, 1'b0);

      // High wave through reset release must not count.
      reset_n = 1'b1;
      p = 0;
      repeat (5) begin cyc(); p += int'(sec_pulse); end
      chk_n("high_at_release_pulses", p, 0);
      chk_t("high_at_release_time", 24'h000000);

      // Exact latency: first sampled high at edge k, update at edge k+2.
      sec_wave = 1'b0;
      repeat (3) cyc();
      sec_wave = 1'b1;
      cyc();
      chk_b("lat_k0_pulse", sec_pulse, 1'b0);
      cyc();
      chk_b("lat_k1_pulse", sec_pulse, 1'b0);
      chk_t("lat_k1_time", 24'h000000);
      cyc();
      chk_b("lat_k2_pulse", sec_pulse, 1'b1);
      chk_t("lat_k2_time", 24'h000001);
      cyc();
      chk_b("lat_k3_pulse", sec_pulse, 1'b0);

      // Day wrap.
      do_set(8'h23, 8'h59, 8'h58, a, e);
      chk_b("load_235958_ack", a, 1'b1);
      chk_b("load_235958_err", e, 1'b0);
      chk_t("load_235958_time", 24'h235958);
      sec_edge(p, r);
      chk_n("wrap1_pulses", p, 1);
      chk_n("wrap1_rolls", r, 0);
      chk_t("wrap1_time", 24'h235959);
      sec_edge(p, r);
      chk_n("wrap2_pulses", p, 1);
      chk_n("wrap2_rolls", r, 1);
      chk_t("wrap2_time", 24'h000000);

      // Rejected loads.
      do_set(8'h12, 8'h5A, 8'h00, a, e);
      chk_b("bad_nibble_ack", a, 1'b1);
      chk_b("bad_nibble_err", e, 1'b1);
      chk_t("bad_nibble_time", 24'h000000);
      do_set(8'h24, 8'h00, 8'h00, a, e);
      chk_b("bad_hour_ack", a, 1'b1);
      chk_b("bad_hour_err", e, 1'b1);
      chk_t("bad_hour_time", 24'h000000);
      do_set(8'h12, 8'h60, 8'h00, a, e);
      chk_b("bad_min_err", e, 1'b1);
      do_set(8'h12, 8'h34, 8'h56, a, e);
      chk_b("good_load_err", e, 1'b0);
      chk_t("good_load_time", 24'h123456);

      // run = 0 holds time.
      run = 1'b0;
      acks = 0;
      repeat (5) begin sec_edge(p, r); acks += p; end
      chk_n("hold_pulses", acks, 0);
      chk_t("hold_time", 24'h123456);
      run = 1'b1;
      sec_edge(p, r);
      chk_n("resume_pulses", p, 1);
      chk_t("resume_time", 24'h123457);

      // Held request with a tick landing in CHECK.
      sec_wave = 1'b0;
      repeat (3) cyc();
      sec_wave = 1'b1;
      cyc();                         // edge k sampled high
      set_hh = 8'h08; set_mm = 8'h15; set_ss = 8'h30;
      set_req = 1'b1;                // IDLE->CHECK at k+1, tick due at k+2
      acks = 0; p = 0;
      repeat (20) begin cyc(); acks += int'(set_ack); p += int'(sec_pulse); end
      set_req = 1'b0;
      cyc();
      chk_n("held_req_acks", acks, 1);
      chk_n("held_req_pulses", p, 0);
      chk_t("held_req_time", 24'h081530);

      // Reset asserted during ACK with request still high.
      set_hh = 8'h10; set_mm = 8'h20; set_ss = 8'h30;
      set_req = 1'b1;
      cyc();
      cyc();
      chk_b("pre_reset_ack", set_ack, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      chk_t("reset_in_ack_time", 24'h000000);
      chk_b("reset_in_ack_ack", set_ack, 1'b0);
      @(negedge clock);
      cyc();
      reset_n = 1'b1;
      acks = 0;
      repeat (6) begin cyc(); acks += int'(set_ack); end
      chk_n("post_reset_acks", acks, 1);
      chk_t("post_reset_time", 24'h102030);
      set_req = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
